// File: rtl/tdm_demux_1x4.sv
// tdm_demux_1x4: receive-side TDM demultiplexer. Consecutive valid words are
// steered to channels 0..3 in rotation, each channel gets a one-cycle valid
// pulse, and a complete 4-word frame is published atomically on slot 3.
// frame_sync forces the current word to slot 0; arriving mid-frame it flags
// sync_err and the partial frame is dropped.
module tdm_demux_1x4 #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               in_valid,
  input  logic               frame_sync,
  output logic [WIDTH-1:0]   data_out0,
  output logic [WIDTH-1:0]   data_out1,
  output logic [WIDTH-1:0]   data_out2,
  output logic [WIDTH-1:0]   data_out3,
  output logic [3:0]         out_valid,
  output logic [4*WIDTH-1:0] frame_out,
  output logic               frame_done,
  output logic               sync_err,
  output logic [1:0]         slot
);

  logic [3:0][WIDTH-1:0] dout_q, dout_d;
  logic [2:0][WIDTH-1:0] stage_q, stage_d;
  logic [4*WIDTH-1:0]    frame_q, frame_d;
  logic [3:0]            ov_q, ov_d;
  logic [2:0]            wr_q, wr_d;
  logic [1:0]            slot_q, slot_d;
  logic                  fd_q, fd_d;
  logic                  se_q, se_d;
  logic [1:0]            es;

  // Next-state: steer the word, advance the slot, and publish on an intact slot 3
  always_comb begin
    dout_d  = dout_q;
    stage_d = stage_q;
    frame_d = frame_q;
    wr_d    = wr_q;
    slot_d  = slot_q;
    ov_d    = 4'b0000;
    fd_d    = 1'b0;
    se_d    = 1'b0;
    es      = frame_sync ? 2'd0 : slot_q;
    if (in_valid) begin
      dout_d[es] = data_in;
      ov_d       = 4'b0001 << es;
      slot_d     = es + 2'd1;
      // A sync on a non-zero slot means the link slipped; drop what we have.
      if (frame_sync && (slot_q != 2'd0)) begin
        se_d = 1'b1;
      end
      // wr tracks which of slots 0..2 have been written since the last slot-0
      // write, so a frame is published only if it was assembled in order.
      case (es)
        2'd0: begin
          stage_d[0] = data_in;
          wr_d       = 3'b001;
        end
        2'd1: begin
          stage_d[1] = data_in;
          wr_d[1]    = 1'b1;
        end
        2'd2: begin
          stage_d[2] = data_in;
          wr_d[2]    = 1'b1;
        end
        2'd3: begin
          if (wr_q == 3'b111) begin
            frame_d = {data_in, stage_q[2], stage_q[1], stage_q[0]};
            fd_d    = 1'b1;
          end
          wr_d = 3'b000;
        end
        default: ;
      endcase
    end
  end

  // State registers; reset clears everything and discards any partial frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q  <= '0;
      stage_q <= '0;
      frame_q <= '0;
      wr_q    <= '0;
      slot_q  <= '0;
      ov_q    <= '0;
      fd_q    <= 1'b0;
      se_q    <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      stage_q <= stage_d;
      frame_q <= frame_d;
      wr_q    <= wr_d;
      slot_q  <= slot_d;
      ov_q    <= ov_d;
      fd_q    <= fd_d;
      se_q    <= se_d;
    end
  end

  assign data_out0  = dout_q[0];
  assign data_out1  = dout_q[1];
  assign data_out2  = dout_q[2];
  assign data_out3  = dout_q[3];
  assign out_valid  = ov_q;
  assign frame_out  = frame_q;
  assign frame_done = fd_q;
  assign sync_err   = se_q;
  assign slot       = slot_q;

endmodule

// File: tb/tb_tdm_demux_1x4.sv
// Directed testbench for tdm_demux_1x4.
module tb_tdm_demux_1x4;

  localparam int WIDTH = 4;

  logic               clk;
  logic               rst_n;
  logic [WIDTH-1:0]   data_in;
  logic               in_valid;
  logic               frame_sync;
  logic [WIDTH-1:0]   data_out0, data_out1, data_out2, data_out3;
  logic [3:0]         out_valid;
  logic [4*WIDTH-1:0] frame_out;
  logic               frame_done;
  logic               sync_err;
  logic [1:0]         slot;

  int total = 0;
  int bad   = 0;

  tdm_demux_1x4 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .in_valid  (in_valid),
    .frame_sync(frame_sync),
    .data_out0 (data_out0),
    .data_out1 (data_out1),
    .data_out2 (data_out2),
    .data_out3 (data_out3),
    .out_valid (out_valid),
    .frame_out (frame_out),
    .frame_done(frame_done),
    .sync_err  (sync_err),
    .slot      (slot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, take the rising edge, sample 1 time unit later.
  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic s);
    in_valid   = v;
    data_in    = d;
    frame_sync = s;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] all;
    all = {slot, out_valid, frame_done, sync_err, frame_out, data_out0, data_out1};
    total++;
    if (all !== 32'h0 || data_out2 !== 4'h0 || data_out3 !== 4'h0) begin
      bad++;
      $display("FAIL reset_state got=%h d2=%h d3=%h exp=0", all, data_out2, data_out3);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [3:0] exp_ov;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 4'(i + 1), i == 0);
      exp_ov = 4'b0001 << i;
      total++;
      if (out_valid !== exp_ov) begin
        bad++; $display("FAIL basic_ov[%0d] got=%b exp=%b", i, out_valid, exp_ov);
      end
      total++;
      if (frame_done !== (i == 3)) begin
        bad++; $display("FAIL basic_fd[%0d] got=%b exp=%b", i, frame_done, i == 3);
      end
      total++;
      if (slot !== 2'((i + 1) % 4)) begin
        bad++; $display("FAIL basic_slot[%0d] got=%0d exp=%0d", i, slot, (i + 1) % 4);
      end
    end
    total++;
    if ({data_out3, data_out2, data_out1, data_out0} !== 16'h4321) begin
      bad++; $display("FAIL basic_dout got=%h exp=4321", {data_out3, data_out2, data_out1, data_out0});
    end
    total++;
    if (frame_out !== 16'h4321) begin
      bad++; $display("FAIL basic_frame got=%h exp=4321", frame_out);
    end
    step(1'b0, 4'h0, 1'b0);
    total++;
    if (out_valid !== 4'b0000 || frame_done !== 1'b0) begin
      bad++; $display("FAIL basic_idle ov=%b fd=%b exp=0", out_valid, frame_done);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_frame [8];
    exp_frame = '{16'h4321, 16'h4321, 16'h4321, 16'h3210,
                  16'h3210, 16'h3210, 16'h3210, 16'h7654};
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 4'(i), i == 0);
      total++;
      if (frame_done !== (i % 4 == 3)) begin
        bad++; $display("FAIL b2b_fd[%0d] got=%b exp=%b", i, frame_done, i % 4 == 3);
      end
      total++;
      if (frame_out !== exp_frame[i]) begin
        bad++; $display("FAIL b2b_frame[%0d] got=%h exp=%h", i, frame_out, exp_frame[i]);
      end
      total++;
      if (slot !== 2'((i + 1) % 4)) begin
        bad++; $display("FAIL b2b_slot[%0d] got=%0d exp=%0d", i, slot, (i + 1) % 4);
      end
    end
  endtask

  task automatic test_gaps();
    logic [3:0] words [4];
    words = '{4'hA, 4'hB, 4'hC, 4'hD};
    step(1'b1, words[0], 1'b1);
    for (int g = 0; g < 2; g++) begin
      step(1'b0, 4'hF, 1'b0);
      total++;
      if (out_valid !== 4'b0 || frame_done !== 1'b0 || data_out0 !== 4'hA || slot !== 2'd1) begin
        bad++; $display("FAIL gap1[%0d] ov=%b fd=%b d0=%h slot=%0d exp ov=0 fd=0 d0=a slot=1",
                        g, out_valid, frame_done, data_out0, slot);
      end
    end
    step(1'b1, words[1], 1'b0);
    for (int g = 0; g < 2; g++) begin
      step(1'b0, 4'hF, 1'b0);
      total++;
      if (out_valid !== 4'b0 || data_out1 !== 4'hB || frame_out !== 16'h7654) begin
        bad++; $display("FAIL gap2[%0d] ov=%b d1=%h frame=%h exp ov=0 d1=b frame=7654",
                        g, out_valid, data_out1, frame_out);
      end
    end
    step(1'b1, words[2], 1'b0);
    step(1'b1, words[3], 1'b0);
    total++;
    if (frame_out !== 16'hDCBA || frame_done !== 1'b1 || out_valid !== 4'b1000) begin
      bad++; $display("FAIL gap_frame got=%h fd=%b ov=%b exp=dcba fd=1 ov=1000",
                      frame_out, frame_done, out_valid);
    end
  endtask

  task automatic test_resync();
    step(1'b1, 4'h5, 1'b1);
    step(1'b1, 4'h6, 1'b0);
    total++;
    if (sync_err !== 1'b0) begin
      bad++; $display("FAIL resync_pre got=%b exp=0", sync_err);
    end
    step(1'b1, 4'h9, 1'b1);
    total++;
    if (sync_err !== 1'b1 || data_out0 !== 4'h9 || out_valid !== 4'b0001) begin
      bad++; $display("FAIL resync_err se=%b d0=%h ov=%b exp se=1 d0=9 ov=0001",
                      sync_err, data_out0, out_valid);
    end
    total++;
    if (slot !== 2'd1 || frame_done !== 1'b0 || frame_out !== 16'hDCBA) begin
      bad++; $display("FAIL resync_state slot=%0d fd=%b frame=%h exp slot=1 fd=0 frame=dcba",
                      slot, frame_done, frame_out);
    end
    step(1'b1, 4'hA, 1'b0);
    total++;
    if (sync_err !== 1'b0) begin
      bad++; $display("FAIL resync_once got=%b exp=0", sync_err);
    end
    step(1'b1, 4'hB, 1'b0);
    total++;
    if (frame_done !== 1'b0) begin
      bad++; $display("FAIL resync_nofd got=%b exp=0", frame_done);
    end
    step(1'b1, 4'hC, 1'b0);
    total++;
    if (frame_out !== 16'hCBA9 || frame_done !== 1'b1) begin
      bad++; $display("FAIL resync_frame got=%h fd=%b exp=cba9 fd=1", frame_out, frame_done);
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 4'h1, 1'b1);
    step(1'b1, 4'h2, 1'b0);
    step(1'b1, 4'h3, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({slot, out_valid, frame_done, sync_err} !== 8'h0 || frame_out !== 16'h0 ||
        {data_out3, data_out2, data_out1, data_out0} !== 16'h0) begin
      bad++; $display("FAIL async_rst slot=%0d ov=%b fd=%b se=%b frame=%h dout=%h exp=0",
                      slot, out_valid, frame_done, sync_err, frame_out,
                      {data_out3, data_out2, data_out1, data_out0});
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 4'h8, 1'b0);
    step(1'b1, 4'h7, 1'b0);
    step(1'b1, 4'h6, 1'b0);
    step(1'b1, 4'h5, 1'b0);
    total++;
    if (frame_out !== 16'h5678 || frame_done !== 1'b1 || slot !== 2'd0) begin
      bad++; $display("FAIL post_rst_frame got=%h fd=%b slot=%0d exp=5678 fd=1 slot=0",
                      frame_out, frame_done, slot);
    end
  endtask

  task automatic test_sync_idle();
    step(1'b1, 4'h1, 1'b1);
    step(1'b1, 4'h2, 1'b0);
    step(1'b0, 4'hE, 1'b1);
    total++;
    if (sync_err !== 1'b0 || slot !== 2'd2 || out_valid !== 4'b0 || data_out0 !== 4'h1) begin
      bad++; $display("FAIL sync_idle se=%b slot=%0d ov=%b d0=%h exp se=0 slot=2 ov=0 d0=1",
                      sync_err, slot, out_valid, data_out0);
    end
    step(1'b1, 4'h3, 1'b0);
    step(1'b1, 4'h4, 1'b0);
    total++;
    if (frame_out !== 16'h4321 || frame_done !== 1'b1) begin
      bad++; $display("FAIL sync_idle_frame got=%h fd=%b exp=4321 fd=1", frame_out, frame_done);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    data_in    = '0;
    frame_sync = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_gaps();
    test_resync();
    test_async_reset();
    test_sync_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
